// File: rtl/vec_state_sequencer_if.sv
// vec_state_sequencer_if
// Bus bundle between the state sequencer, the 16x32 vector register file
// and the byte-lane transform unit.
//
// Signals:
//   rf_fila1/rf_fila2/rf_columna  register-file row/column addressing
//   rf_wr_en/rf_col_read/rf_col_write  register-file access controls
//   rf_data_in / rf_data_out1     register-file write / combinational read data
//   req_valid/req_ready/req_data/req_idx/req_mode  word offered to the transform unit
//   resp_valid/resp_ready/resp_data                transform result back
//   dbg_state                     sequencer FSM state (observation only)
//
// Handshake rule for both req_* and resp_*: a transfer happens on a rising
// edge where valid and ready are both high. Once valid is raised it stays
// high, with its payload unchanged, until that transfer.
//
// Modports: master = sequencer side, slave = register file / transform side.
interface vec_state_sequencer_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        rf_fila1;
  logic [3:0]        rf_fila2;
  logic [1:0]        rf_columna;
  logic              rf_wr_en;
  logic              rf_col_read;
  logic              rf_col_write;
  logic [DATA_W-1:0] rf_data_in;
  logic [DATA_W-1:0] rf_data_out1;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic [1:0]        req_idx;
  logic              req_mode;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [2:0]        dbg_state;

  modport master (
    output rf_fila1, rf_fila2, rf_columna, rf_wr_en, rf_col_read, rf_col_write,
    output rf_data_in,
    input  rf_data_out1,
    output req_valid, req_data, req_idx, req_mode,
    input  req_ready,
    input  resp_valid, resp_data,
    output resp_ready,
    output dbg_state
  );

  modport slave (
    input  rf_fila1, rf_fila2, rf_columna, rf_wr_en, rf_col_read, rf_col_write,
    input  rf_data_in,
    output rf_data_out1,
    input  req_valid, req_data, req_idx, req_mode,
    output req_ready,
    output resp_valid, resp_data,
    input  resp_ready,
    input  dbg_state
  );
endinterface

// File: rtl/vec_state_sequencer.sv
// vec_state_sequencer
// Walks the four columns (mode=0) or four rows (mode=1) of one 4x4-byte AES
// state block held in rows block*4..block*4+3 of the vector register file.
// Each element is read, offered to the transform unit, its result awaited,
// and written back to the same column/row.
//
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start       one-cycle request, honoured only in IDLE
//   mode        0 = column pass, 1 = row pass (latched with start)
//   block       state block index (latched with start)
//   abort       synchronous cancel, wins over everything except reset
//   busy        high from the cycle after acceptance through DONE
//   done        one-cycle pulse in DONE
//   bus         register-file and transform-unit signals (master side)
//
// All outputs are registered: each transition loads the output values that
// belong to the state being entered, so outputs never depend on inputs
// combinationally.
module vec_state_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic mode,
  input  logic [1:0] block,
  input  logic abort,
  output logic busy,
  output logic done,
  vec_state_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [1:0]        idx;
  logic              mode_q;
  logic [1:0]        block_q;
  logic [DATA_W-1:0] req_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        fila1_q;
  logic [1:0]        columna_q;
  logic              wr_en_q;
  logic              col_read_q;
  logic              col_write_q;
  logic              req_valid_q;
  logic              resp_ready_q;

  // Column pass: row address is the block base, element picks the byte lane.
  // Row pass: element picks the row, lane select unused.
  function automatic logic [3:0] elem_row(input logic m, input logic [1:0] b,
                                          input logic [1:0] i);
    elem_row = m ? {b, i} : {b, 2'b00};
  endfunction

  function automatic logic [1:0] elem_col(input logic m, input logic [1:0] i);
    elem_col = m ? 2'b00 : i;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= 2'd0;
      mode_q       <= 1'b0;
      block_q      <= 2'd0;
      req_q        <= '0;
      wdata_q      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fila1_q      <= 4'd0;
      columna_q    <= 2'd0;
      wr_en_q      <= 1'b0;
      col_read_q   <= 1'b0;
      col_write_q  <= 1'b0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
    end else begin
      // Every output defaults to its idle value; the state being entered
      // re-asserts whatever it needs.
      done         <= 1'b0;
      fila1_q      <= 4'd0;
      columna_q    <= 2'd0;
      wr_en_q      <= 1'b0;
      col_read_q   <= 1'b0;
      col_write_q  <= 1'b0;
      wdata_q      <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;

      if (abort) begin
        // Also covers start+abort in IDLE: start is dropped.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              mode_q     <= mode;
              block_q    <= block;
              idx        <= 2'd0;
              busy       <= 1'b1;
              state      <= READ;
              fila1_q    <= elem_row(mode, block, 2'd0);
              columna_q  <= elem_col(mode, 2'd0);
              col_read_q <= ~mode;
            end
          end
          READ: begin
            req_q       <= bus.rf_data_out1;
            req_valid_q <= 1'b1;
            state       <= REQ;
          end
          REQ: begin
            if (bus.req_ready) begin
              resp_ready_q <= 1'b1;
              state        <= WAIT;
            end else begin
              req_valid_q <= 1'b1;
            end
          end
          WAIT: begin
            if (bus.resp_valid) begin
              wdata_q     <= bus.resp_data;
              wr_en_q     <= 1'b1;
              fila1_q     <= elem_row(mode_q, block_q, idx);
              columna_q   <= elem_col(mode_q, idx);
              col_write_q <= ~mode_q;
              state       <= WRITE;
            end else begin
              resp_ready_q <= 1'b1;
            end
          end
          WRITE: begin
            if (idx == 2'd3) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx        <= idx + 2'd1;
              fila1_q    <= elem_row(mode_q, block_q, idx + 2'd1);
              columna_q  <= elem_col(mode_q, idx + 2'd1);
              col_read_q <= ~mode_q;
              state      <= READ;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rf_fila1     = fila1_q;
  assign bus.rf_fila2     = 4'd0;
  assign bus.rf_columna   = columna_q;
  assign bus.rf_wr_en     = wr_en_q;
  assign bus.rf_col_read  = col_read_q;
  assign bus.rf_col_write = col_write_q;
  assign bus.rf_data_in   = wdata_q;
  assign bus.req_valid    = req_valid_q;
  assign bus.req_data     = req_q;
  assign bus.req_idx      = idx;
  assign bus.req_mode     = mode_q;
  assign bus.resp_ready   = resp_ready_q;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_vec_state_sequencer.sv
// tb_vec_state_sequencer
// Bench for vec_state_sequencer: register-file model, transform-unit model
// with programmable/random stalls, an expected-request scoreboard and a
// byte-level reference model of the register-file contents.
module tb_vec_state_sequencer;
  localparam int EW = 35;  // {req_mode, req_idx, req_data}

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic start;
  logic mode;
  logic [1:0] blk;
  logic abort;
  logic busy;
  logic done;

  vec_state_sequencer_if bus_if ();

  vec_state_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .block (blk),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [127:0] outs();
    outs = 128'({busy, done, bus_if.rf_fila1, bus_if.rf_fila2, bus_if.rf_columna,
                 bus_if.rf_wr_en, bus_if.rf_col_read, bus_if.rf_col_write,
                 bus_if.rf_data_in, bus_if.req_valid, bus_if.req_data,
                 bus_if.req_idx, bus_if.req_mode, bus_if.resp_ready});
  endfunction

  // ---------------- register-file model ----------------
  logic [31:0] mem [16];
  logic [31:0] load_img [16];
  logic        load_en;

  always_comb begin
    bus_if.rf_data_out1 = mem[bus_if.rf_fila1];
    if (bus_if.rf_col_read) begin
      for (int r = 0; r < 4; r++)
        bus_if.rf_data_out1[31-8*r -: 8] =
          mem[(int'(bus_if.rf_fila1) + r) % 16][31-8*int'(bus_if.rf_columna) -: 8];
    end
  end

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 16; i++) mem[i] <= load_img[i];
    end else if (bus_if.rf_wr_en) begin
      if (bus_if.rf_col_write) begin
        for (int r = 0; r < 4; r++)
          mem[(int'(bus_if.rf_fila1) + r) % 16][31-8*int'(bus_if.rf_columna) -: 8]
            <= bus_if.rf_data_in[31-8*r -: 8];
      end else begin
        mem[bus_if.rf_fila1] <= bus_if.rf_data_in;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [16];
  int          cur_op;
  logic [31:0] cur_key;

  function automatic logic [31:0] xform(input int op, input logic [31:0] key, input logic [31:0] w);
    case (op)
      0:       xform = w ^ key;
      1:       xform = w + 32'd1;
      default: xform = {w[23:0], w[31:24]} ^ key;
    endcase
  endfunction

  // Element i of a column pass gathers byte lane i of the four block rows,
  // first block row in the top byte.
  function automatic logic [31:0] model_read(input logic m, input int b, input int i);
    logic [31:0] w;
    w = 32'd0;
    if (m) return ref_mem[b*4+i];
    for (int r = 0; r < 4; r++)
      w = w | (((ref_mem[b*4+r] >> (8*(3-i))) & 32'hFF) << (8*(3-r)));
    return w;
  endfunction

  task automatic model_write(input logic m, input int b, input int i, input logic [31:0] w);
    logic [31:0] mask;
    logic [31:0] byte_v;
    if (m) begin
      ref_mem[b*4+i] = w;
    end else begin
      mask = 32'hFF << (8*(3-i));
      for (int r = 0; r < 4; r++) begin
        byte_v = (w >> (8*(3-r))) & 32'hFF;
        ref_mem[b*4+r] = (ref_mem[b*4+r] & ~mask) | (byte_v << (8*(3-i)));
      end
    end
  endtask

  // ---------------- transform-unit model ----------------
  int  req_dly_q[$];
  int  resp_dly_q[$];
  bit  tu_rand;

  function automatic int pick_dly(input int qd);
    pick_dly = (qd >= 0) ? qd : (tu_rand ? int'($urandom_range(0, 3)) : 0);
  endfunction

  initial begin
    int phase;
    int cnt;
    int dly;
    bit loaded;
    logic [31:0] cap;
    logic [31:0] res;
    phase = 0; cnt = 0; dly = 0; loaded = 0; cap = 0; res = 0;
    bus_if.req_ready  = 1'b0;
    bus_if.resp_valid = 1'b0;
    bus_if.resp_data  = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0; loaded = 0; cnt = 0;
        bus_if.req_ready  = 1'b0;
        bus_if.resp_valid = 1'b0;
      end else begin
        if (phase == 0) begin
          if (bus_if.req_ready && !bus_if.req_valid) begin
            bus_if.req_ready = 1'b0;
            res = xform(cur_op, cur_key, cap);
            phase = 1; loaded = 0; cnt = 0;
          end else if (bus_if.req_valid && !bus_if.req_ready) begin
            if (!loaded) begin
              dly = pick_dly(req_dly_q.size() > 0 ? req_dly_q.pop_front() : -1);
              loaded = 1; cnt = 0;
            end
            if (cnt >= dly) begin
              bus_if.req_ready = 1'b1;
              cap = bus_if.req_data;
            end else cnt++;
          end
        end
        if (phase == 1) begin
          if (!busy) begin
            phase = 0; loaded = 0;
            bus_if.resp_valid = 1'b0;
          end else if (bus_if.resp_valid && !bus_if.resp_ready) begin
            bus_if.resp_valid = 1'b0;
            phase = 0; loaded = 0;
          end else if (bus_if.resp_ready && !bus_if.resp_valid) begin
            if (!loaded) begin
              dly = pick_dly(resp_dly_q.size() > 0 ? resp_dly_q.pop_front() : -1);
              loaded = 1; cnt = 0;
            end
            if (cnt >= dly) begin
              bus_if.resp_valid = 1'b1;
              bus_if.resp_data  = res;
            end else cnt++;
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev_v;
    logic [EW-1:0] held;
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    prev_v = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        got = {bus_if.req_mode, bus_if.req_idx, bus_if.req_data};
        if (bus_if.req_valid && !prev_v) begin
          if (exp_q.size() == 0) check("req_unexpected", 128'(exp_q.size()), 128'd1);
          else begin
            e = exp_q.pop_front();
            check("req_word", 128'(got), 128'(e));
          end
          held = got;
        end else if (bus_if.req_valid && prev_v) begin
          check("req_stable", 128'(got), 128'(held));
        end
        if (bus_if.req_valid || bus_if.resp_ready)
          check("rf_quiet_stall", 128'({bus_if.rf_wr_en, bus_if.rf_col_read, bus_if.rf_col_write,
                 bus_if.rf_fila1, bus_if.rf_columna, bus_if.rf_data_in}), 128'd0);
        if (busy && bus_if.req_mode)
          check("row_no_colsel", 128'({bus_if.rf_col_read, bus_if.rf_col_write}), 128'd0);
        if (busy) check("fila2_zero", 128'(bus_if.rf_fila2), 128'd0);
        prev_v = bus_if.req_valid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_all();
    for (int i = 0; i < 16; i++) load_img[i] = ref_mem[i];
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // kind: 0 = full pass, 1 = abort in WAIT of stop_elem, 2 = reset in REQ of stop_elem
  task automatic do_pass(input logic m, input logic [1:0] b, input int kind,
                         input int stop_elem, input bit noisy, input int exp_done_cyc);
    logic [31:0] w;
    int cyc;
    int n_done;
    int hits;
    for (int i = 0; i < 4; i++) begin
      if (kind != 0 && i > stop_elem) break;
      w = model_read(m, int'(b), i);
      exp_q.push_back({m, i[1:0], w});
      if (kind == 0 || i < stop_elem) model_write(m, int'(b), i, xform(cur_op, cur_key, w));
    end
    start = 1'b1; mode = m; blk = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; n_done = 0; hits = 0;
    check("busy_after_start", 128'(busy), 128'd1);
    while (cyc < 400) begin
      if (done) begin
        n_done++;
        if (exp_done_cyc > 0) check("done_cycle", 128'(cyc), 128'(exp_done_cyc));
      end
      if (kind == 0 && done) break;
      if (kind == 1 && bus_if.resp_ready && int'(bus_if.req_idx) == stop_elem) begin
        abort = 1'b1;
        break;
      end
      if (kind == 2 && bus_if.req_valid && int'(bus_if.req_idx) == stop_elem) begin
        hits++;
        if (hits == 2) begin
          rst_n = 1'b0;
          break;
        end
      end
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        mode  = 1'($urandom);
        blk   = 2'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 400) check("pass_timeout", 128'(cyc), 128'd0);
    if (kind == 0) begin
      @(negedge clk);
      check("idle_after_done", 128'(busy), 128'd0);
      repeat (3) begin
        @(negedge clk);
        if (done) n_done++;
      end
      check("done_pulses", 128'(n_done), 128'd1);
    end else if (kind == 1) begin
      @(negedge clk);
      abort = 1'b0;
      check("busy_after_abort", 128'(busy), 128'd0);
      repeat (3) begin
        if (done) n_done++;
        @(negedge clk);
      end
      check("no_done_abort", 128'(n_done), 128'd0);
    end else begin
      #1;
      check("outs_in_reset", outs(), 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("no_done_reset", 128'(n_done), 128'd0);
    end
    repeat (2) @(negedge clk);
    check("exp_q_drained", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) check($sformatf("mem_row%0d", i), 128'(mem[i]), 128'(ref_mem[i]));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b1; start = 1'b0; mode = 1'b0; blk = 2'd0; abort = 1'b0;
    load_en = 1'b0; cur_op = 0; cur_key = 32'd0; tu_rand = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    #2 rst_n = 1'b0;
    #1 check("outs_reset", outs(), 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // column pass, block 1, invert every byte
    ref_mem[4] = 32'h00112233; ref_mem[5] = 32'h44556677;
    ref_mem[6] = 32'h8899AABB; ref_mem[7] = 32'hCCDDEEFF;
    load_all();
    cur_op = 0; cur_key = 32'hFFFFFFFF;
    do_pass(1'b0, 2'd1, 0, 0, 1'b0, 17);
    check("dir_row4", 128'(mem[4]), 128'h FFEEDDCC);
    check("dir_row5", 128'(mem[5]), 128'h BBAA9988);
    check("dir_row6", 128'(mem[6]), 128'h 77665544);
    check("dir_row7", 128'(mem[7]), 128'h 33221100);

    // row pass, block 3, +1 per word
    ref_mem[12] = 32'h01020304;
    load_all();
    cur_op = 1;
    do_pass(1'b1, 2'd3, 0, 0, 1'b0, 17);
    check("dir_row12", 128'(mem[12]), 128'h 01020305);

    // backpressure on the first element: 5 cycles of req_ready low, 3 of resp_valid late
    cur_op = 2; cur_key = $urandom;
    req_dly_q.push_back(5);
    resp_dly_q.push_back(3);
    do_pass(1'b0, 2'd2, 0, 0, 1'b0, 25);

    // abort in WAIT of element 2, column mode
    cur_op = 0; cur_key = $urandom;
    do_pass(1'b0, 2'd0, 1, 2, 1'b0, 0);

    // start and abort together in IDLE: nothing starts
    start = 1'b1; abort = 1'b1; mode = 1'b0; blk = 2'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_start_abort", 128'(busy), 128'd0);
    @(negedge clk);

    // start pulses while busy are ignored
    cur_op = 1;
    do_pass(1'b1, 2'd1, 0, 0, 1'b1, 17);

    // reset during REQ of element 1, then a clean pass
    cur_op = 0; cur_key = $urandom;
    req_dly_q.push_back(0);
    req_dly_q.push_back(3);
    resp_dly_q.push_back(0);
    do_pass(1'b0, 2'd2, 2, 1, 1'b0, 0);
    do_pass(1'b0, 2'd2, 0, 0, 1'b0, 17);

    // randomized passes with random stalls
    tu_rand = 1'b1;
    repeat (20) begin
      cur_op = int'($urandom_range(0, 2));
      cur_key = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        load_all();
      end
      do_pass(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0, 0,
              1'($urandom_range(0, 1)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
